// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative right-shift unit.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned SHAMT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_unit.sv
// Iterative right shifter: one bit per clock through a 2*WIDTH register,
// producing the shifted operand and the MSB-aligned bits shifted out.
module shift_right_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   DataIn,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result,
  output logic [WIDTH-1:0]   OvOut
);

  state_t               state, state_d;
  logic [SHAMT_W-1:0]   cnt, cnt_d;
  logic [2*WIDTH-1:0]   sr, sr_d;
  logic                 fill, fill_d;
  logic                 busy_d, done_d;
  logic                 accept;

  // State, counter, shift register and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      fill  <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sr    <= sr_d;
      fill  <= fill_d;
      Busy  <= busy_d;
      Done  <= done_d;
    end
  end

  // Next-state, datapath update and status decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sr_d    = sr;
    fill_d  = fill;
    accept  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (Start) accept = 1'b1;
      end
      SHIFT: begin
        sr_d = {fill, sr[2*WIDTH-1:1]};
        if (cnt != '0) cnt_d = SHAMT_W'(cnt - SHAMT_W'(1));
        if (cnt <= SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (Start) accept = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepting clears the shifted-out half and latches the fill bit once
    if (accept) begin
      sr_d    = {DataIn, {WIDTH{1'b0}}};
      fill_d  = Arith & DataIn[WIDTH-1];
      cnt_d   = Shamt;
      state_d = (Shamt != '0) ? SHIFT : DONE;
    end

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign Result = sr[2*WIDTH-1:WIDTH];
  assign OvOut  = sr[WIDTH-1:0];

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed-vector bench for shift_right_unit with hand-computed expectations.
module tb_shift_right_unit;

  logic       clk;
  logic       reset;
  logic       Start;
  logic [7:0] DataIn;
  logic [2:0] Shamt;
  logic       Arith;
  logic       Busy;
  logic       Done;
  logic [7:0] Result;
  logic [7:0] OvOut;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  shift_right_unit #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .DataIn (DataIn),
    .Shamt  (Shamt),
    .Arith  (Arith),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .OvOut  (OvOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start in cycle N, then check Busy/Done each cycle through N+s+1 and the final result
  task automatic do_op(input string tag, input logic [7:0] d, input logic [2:0] s,
                       input logic a, input logic [7:0] er, input logic [7:0] eo);
    @(negedge clk);
    Start  = 1'b1;
    DataIn = d;
    Shamt  = s;
    Arith  = a;
    @(negedge clk);
    Start  = 1'b0;
    DataIn = 8'hxx;
    Shamt  = 3'bxxx;
    Arith  = 1'bx;
    for (int k = 1; k <= int'(s) + 1; k++) begin
      if (k > 1) @(negedge clk);
      check({tag, "_busy"}, 32'(Busy), 32'(k <= int'(s)));
      check({tag, "_done"}, 32'(Done), 32'(k == int'(s) + 1));
    end
    check({tag, "_result"}, 32'(Result), 32'(er));
    check({tag, "_ovout"},  32'(OvOut),  32'(eo));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(Done), 32'd0);
    check({tag, "_hold_res"},  32'(Result), 32'(er));
    check({tag, "_hold_ov"},   32'(OvOut),  32'(eo));
  endtask

  initial begin
    reset  = 1'b1;
    Start  = 1'b1;
    DataIn = 8'hFF;
    Shamt  = 3'd3;
    Arith  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(Busy),   32'd0);
    check("rst_done",   32'(Done),   32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_ovout",  32'(OvOut),  32'd0);
    reset = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    check("idle_done", 32'(Done), 32'd0);

    do_op("b4_log",   8'hB4, 3'd3, 1'b0, 8'h16, 8'h80);
    do_op("b4_ari",   8'hB4, 3'd3, 1'b1, 8'hF6, 8'h80);
    do_op("5a_zero",  8'h5A, 3'd0, 1'b0, 8'h5A, 8'h00);
    do_op("81_log",   8'h81, 3'd7, 1'b0, 8'h01, 8'h02);
    do_op("81_ari",   8'h81, 3'd7, 1'b1, 8'hFF, 8'h02);
    do_op("7f_ari",   8'h7F, 3'd1, 1'b1, 8'h3F, 8'h80);
    do_op("c3_ari",   8'hC3, 3'd2, 1'b1, 8'hF0, 8'hC0);

    // Start during SHIFT is ignored; Start during DONE is accepted back-to-back
    @(negedge clk);
    Start = 1'b1; DataIn = 8'hB4; Shamt = 3'd3; Arith = 1'b0;
    @(negedge clk);
    check("ign_busy1", 32'(Busy), 32'd1);
    DataIn = 8'hFF; Shamt = 3'd1; Arith = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("ign_busy2", 32'(Busy), 32'd1);
    check("ign_done2", 32'(Done), 32'd0);
    @(negedge clk);
    check("ign_busy3", 32'(Busy), 32'd1);
    check("ign_done3", 32'(Done), 32'd0);
    @(negedge clk);
    check("ign_done4", 32'(Done),   32'd1);
    check("ign_busy4", 32'(Busy),   32'd0);
    check("ign_res",   32'(Result), 32'h16);
    check("ign_ov",    32'(OvOut),  32'h80);
    Start = 1'b1; DataIn = 8'h5A; Shamt = 3'd1; Arith = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    check("b2b_busy5", 32'(Busy), 32'd1);
    check("b2b_done5", 32'(Done), 32'd0);
    @(negedge clk);
    check("b2b_done6", 32'(Done),   32'd1);
    check("b2b_res",   32'(Result), 32'h2D);
    check("b2b_ov",    32'(OvOut),  32'h00);
    @(negedge clk);
    check("b2b_done7", 32'(Done),   32'd0);
    check("b2b_hold",  32'(Result), 32'h2D);

    // Reset asserted mid-shift aborts with no Done
    @(negedge clk);
    Start = 1'b1; DataIn = 8'hB4; Shamt = 3'd5; Arith = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("abort_busy1", 32'(Busy), 32'd1);
    @(negedge clk);
    check("abort_busy2", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(Busy),   32'd0);
    check("abort_done", 32'(Done),   32'd0);
    check("abort_res",  32'(Result), 32'h00);
    check("abort_ov",   32'(OvOut),  32'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_nodone", 32'(Done), 32'd0);
      check("abort_nobusy", 32'(Busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data path width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port Start, input, 1, request to begin a shift; sampled each rising edge.
REQ-005 SHALL have port DataIn, input, WIDTH, operand captured when Start is accepted.
REQ-006 SHALL have port Shamt, input, 3, shift amount 0-7, captured with DataIn.
REQ-007 SHALL have port Arith, input, 1; 1 = arithmetic (sign-fill), 0 = logical (zero-fill), captured with DataIn.
REQ-008 SHALL have port Busy, output, 1, high while shifting.
REQ-009 SHALL have port Done, output, 1, one-cycle pulse when the result is final.
REQ-010 SHALL have port Result, output, WIDTH, shifted operand.
REQ-011 SHALL have port OvOut, output, WIDTH, bits shifted out, MSB-aligned.

Function
REQ-012 SHALL compute {Result, OvOut} = {DataIn, WIDTH'b0} shifted right by Shamt; fill bit = DataIn MSB if Arith, else 0.
REQ-013 SHALL shift exactly one bit position per clock in the SHIFT state (iterative, no barrel shifter).
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: on Start, capture operands, clear OvOut, load counter = Shamt; go to SHIFT if Shamt != 0, else DONE.
REQ-016 SHIFT: each cycle, shift {Result, OvOut} right by 1 with fill bit, decrement counter; when counter reaches 0, go to DONE.
REQ-017 DONE: assert Done for one cycle; on Start, behave as IDLE+Start (back-to-back accept); otherwise go to IDLE.
REQ-018 Latency: Start high in cycle N SHALL give Done high in cycle N+Shamt+1 (Shamt=0 -> N+1, Shamt=7 -> N+8).
REQ-019 Busy SHALL be high exactly in SHIFT state cycles.
REQ-020 Start while in SHIFT SHALL be ignored; operands and progress unchanged.
REQ-021 Result and OvOut SHALL hold their final values after Done until the next accepted Start.
REQ-022 Operand inputs SHALL be don't-care except in the cycle Start is accepted.
REQ-023 Counter SHALL be 3 bits and SHALL never wrap below 0.

Reset
REQ-024 reset high at a rising edge SHALL force IDLE, Busy=0, Done=0, Result=0, OvOut=0, counter=0.
REQ-025 reset SHALL override Start and abort any shift in progress; no Done is issued for the aborted operation.
REQ-026 Outputs SHALL take reset values in the cycle after the reset edge.

Structure
REQ-027 Shared package shift_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-028 Block SHALL be a single module, no sub-modules; one FSM, one counter, one 2*WIDTH shift register.

Verification
REQ-029 DataIn=8'hB4, Shamt=3, Arith=0, Start in cycle N -> Busy cycles N+1..N+3, Done in N+4, Result=8'h16, OvOut=8'h80.
REQ-030 DataIn=8'hB4, Shamt=3, Arith=1 -> Result=8'hF6, OvOut=8'h80, Done in N+4.
REQ-031 DataIn=8'h5A, Shamt=0 -> Busy never high, Done in N+1, Result=8'h5A, OvOut=8'h00.
REQ-032 DataIn=8'h81, Shamt=7: Arith=0 -> Result=8'h01, OvOut=8'h02; Arith=1 -> Result=8'hFF, OvOut=8'h02; Done in N+8.
REQ-033 Start pulsed during SHIFT with different DataIn -> ignored, original result unchanged; Start during the Done cycle -> new operation accepted, its Done after new Shamt+1 cycles.
REQ-034 reset asserted mid-SHIFT (Shamt=5, cycle N+2) -> next cycle Busy=0, Result=8'h00, OvOut=8'h00, no Done pulse.
